phy_rx_deserializer: RTL

Serial-to-parallel receiver for the PHY link, the receive-side counterpart of the PHY transmitter. It samples one bit per `clk_32f` cycle from `data_in`, MSB first, and finds byte alignment by detecting the COM symbol 0xBC (bit stream 1,0,1,1,1,1,0,0). After a run of aligned COMs it declares the link active and delivers each non-COM byte as a registered parallel word with a one-cycle valid strobe.

---
 rtl/phy_pkg.sv | 13 +
 rtl/phy_rx_deserializer_if.sv | 27 ++
 rtl/phy_rx_shift8.sv | 18 +
 rtl/phy_rx_deserializer.sv | 103 ++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: link symbols and receiver FSM states.
// Used by both the receive and transmit halves of the link.
package phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/phy_rx_deserializer_if.sv
// Receive-side serial input and parallel output bundle.
// master drives the serial line, slave is the deserializer.
interface phy_rx_deserializer_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [1:0] state_dbg;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  state_dbg
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output state_dbg
  );

endinterface

// File: rtl/phy_rx_shift8.sv
// 8-bit serial-in/parallel-out shifter, MSB first.
// nxt is the byte including the bit sampled on this edge.
module phy_rx_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] sr,
  output logic [7:0] nxt
);

  assign nxt = {sr[6:0], data_in};

  always_ff @(posedge clk_32f) begin
    if (reset) sr <= 8'h00;
    else       sr <= nxt;
  end

endmodule

// File: rtl/phy_rx_deserializer.sv
// PHY receive deserializer: COM-based byte alignment and
// parallel byte delivery with a one-cycle valid strobe.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter logic [7:0] COM       = COM_SYM,
  parameter int         COM_COUNT = 4
) (
  input  logic clk_32f,
  input  logic reset,
  phy_rx_deserializer_if.slave rx
);

  localparam logic [3:0] CC = COM_COUNT[3:0];

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [7:0] data_q;
  logic       valid_q;
  logic       active_q;
  logic [7:0] nxt;
  logic [7:0] sr_unused;
  logic       is_com;
  logic       boundary;
  logic [3:0] com_inc;

  phy_rx_shift8 u_shift (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (rx.data_in),
    .sr      (sr_unused),
    .nxt     (nxt)
  );

  assign is_com   = (nxt == COM);
  assign boundary = (bit_cnt == 3'd7);
  // com_cnt saturates rather than wrapping
  assign com_inc  = (com_cnt == 4'hF) ? com_cnt
                                      : com_cnt + 4'd1;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= SEARCH;
      bit_cnt  <= 3'd0;
      com_cnt  <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_com) begin
            bit_cnt <= 3'd0;
            com_cnt <= 4'd1;
            if (CC == 4'd1) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= LOCK;
            end
          end
        end
        LOCK: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              com_cnt <= com_inc;
              if (com_inc >= CC) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= 4'd0;
              bit_cnt <= 3'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary && !is_com) begin
            data_q  <= nxt;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state    <= SEARCH;
          bit_cnt  <= 3'd0;
          com_cnt  <= 4'd0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.active    = active_q;
  assign rx.state_dbg = state;

endmodule
